// File: rtl/console_input_pkg.sv
// Shared constants for the console input unit: register indices within the
// 4-word CPU window, STATUS/CTRL field positions and character constants.
package console_input_pkg;

  // Register index, taken from addr_i[3:2].
  localparam logic [1:0] DATA   = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] CTRL   = 2'd2;
  localparam logic [1:0] TIME   = 2'd3;

  // STATUS fields.
  localparam int unsigned STATUS_NOT_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT      = 1;
  localparam int unsigned STATUS_COUNT_LSB     = 8;
  localparam int unsigned STATUS_LINES_LSB     = 16;

  // CTRL fields.
  localparam int unsigned CTRL_FLUSH_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam logic [7:0]  NEWLINE        = 8'h0A;
  localparam int unsigned DATA_VALID_BIT = 31;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write one entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   flush_i           empty the FIFO at the next edge (overrides push/pop)
//   rdata_o           head entry, combinational
//   full_o, empty_o   occupancy flags
//   count_o           entries held, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/console_input_unit.sv
// Memory-mapped console input: an external byte source pushes characters over
// a valid/ready handshake into a FIFO; the CPU polls STATUS, pops DATA and can
// flush through CTRL. TIME is a free-running cycle counter.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   addr_i, wdata_cpu_i          CPU byte address (word = addr_i[3:2]), write data
//   wr_en_i, rd_en_i             CPU strobes; reading DATA pops the FIFO
//   data_cpu_o                   read data, one cycle after rd_en_i
//   stall_o                      always 0
//   rx_data_i, rx_valid_i        incoming byte and its valid
//   rx_ready_o                   byte accepted this cycle when high with valid
//   irq_o                        only when CONSOLE_INPUT_UNIT_IRQ_EN is defined:
//                                registered irq_en && (lines != 0)
module console_input_unit
  import console_input_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef CONSOLE_INPUT_UNIT_IRQ_EN
  output logic        irq_o,
`endif
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_cpu_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  output logic [31:0] data_cpu_o,
  output logic        stall_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  logic [1:0]  sel;
  logic        ctrl_wr, flush, push, pop;
  logic [7:0]  head;
  logic        full, empty;
  logic [AW:0] count;
  logic [AW:0] lines_q, lines_d;
  logic [1:0]  rsel_q;
  logic [31:0] rdata_q, data_word, status_word;
  logic        irq_en_q;
  logic [31:0] time_q;
  logic        unused_bits;

  assign sel     = addr_i[3:2];
  assign ctrl_wr = wr_en_i && (sel == CTRL);
  assign flush   = ctrl_wr && wdata_cpu_i[CTRL_FLUSH_BIT];

  // Refuse bytes during a flush write so nothing lands in a FIFO being cleared.
  assign rx_ready_o = !full && !flush;
  assign push       = rx_valid_i && rx_ready_o;
  assign pop        = rd_en_i && (sel == DATA) && !empty;
  assign stall_o    = 1'b0;

  assign unused_bits = ^{wdata_cpu_i[31:2], addr_i[1:0]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (rx_data_i),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    lines_d = lines_q;
    if (push && (rx_data_i == NEWLINE)) lines_d = lines_d + (AW+1)'(1);
    if (pop && (head == NEWLINE))       lines_d = lines_d - (AW+1)'(1);
    if (flush)                          lines_d = '0;
  end

  always_comb begin
    data_word = '0;
    if (!empty) begin
      data_word[DATA_VALID_BIT] = 1'b1;
      data_word[7:0]            = head;
    end
  end

  always_comb begin
    status_word                                 = '0;
    status_word[STATUS_NOT_EMPTY_BIT]           = !empty;
    status_word[STATUS_FULL_BIT]                = full;
    status_word[STATUS_COUNT_LSB +: AW+1]       = count;
    status_word[STATUS_LINES_LSB +: AW+1]       = lines_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lines_q  <= '0;
      rsel_q   <= DATA;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
      time_q   <= '0;
    end else begin
      lines_q <= lines_d;
      time_q  <= time_q + 32'd1;
      if (rd_en_i) begin
        rsel_q <= sel;
        // DATA is captured at strobe time since the pop moves the head.
        if (sel == DATA) rdata_q <= data_word;
      end
      if (ctrl_wr) irq_en_q <= wdata_cpu_i[CTRL_IRQ_EN_BIT];
    end
  end

  always_comb begin
    data_cpu_o = '0;
    unique case (rsel_q)
      DATA:    data_cpu_o = rdata_q;
      STATUS:  data_cpu_o = status_word;
      CTRL:    data_cpu_o[CTRL_IRQ_EN_BIT] = irq_en_q;
      TIME:    data_cpu_o = time_q;
      default: data_cpu_o = '0;
    endcase
  end

`ifdef CONSOLE_INPUT_UNIT_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_en_q && (lines_q != '0);
  end
  assign irq_o = irq_q;
`endif

endmodule
